// File: rtl/sobel_pkg.sv
// Shared widths, border size and small arithmetic helpers for the Sobel
// edge filter that sits between the line buffer and the VGA output stage.
`timescale 1ns/1ps
package sobel_pkg;

  localparam int PIX_W  = 8;
  localparam int SUM_W  = 10;
  localparam int DIFF_W = 11;
  localparam int MAG_W  = 11;
  localparam int CNT_W  = 10;
  localparam int BORDER = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // One 1-2-1 kernel row/column: a + 2*m + c, never exceeds 1020.
  function automatic logic [SUM_W-1:0] tap_sum(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] m,
                                                input logic [PIX_W-1:0] c);
    return SUM_W'(a) + (SUM_W'(m) << 1) + SUM_W'(c);
  endfunction

  function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
    logic signed [DIFF_W-1:0] d;
    logic        [DIFF_W-1:0] m;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    m = d[DIFF_W-1] ? DIFF_W'(-d) : DIFF_W'(d);
    return m[SUM_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_border_ctrl.sv
// Tracks the pixel position inside the frame and flags the first two columns
// and first two lines, where the 3x3 window still holds stale pixels.
`timescale 1ns/1ps
module sobel_border_ctrl
  import sobel_pkg::*;
(
  input  logic pclk,
  input  logic rst_n,
  input  logic de_in,
  input  logic vsync_in,
  output logic mask
);

  logic [CNT_W-1:0] col_cnt;
  logic [CNT_W-1:0] row_cnt;
  logic             de_in_d;

  // NOTE: reset is sampled on pclk only; state uses non-blocking assignments
  // so every register updates from the pre-edge values of its neighbours.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
      de_in_d <= 1'b0;
    end else begin
      de_in_d <= de_in;

      if (!de_in)
        col_cnt <= '0;
      else if (col_cnt != CNT_MAX)
        col_cnt <= col_cnt + 1'b1;

      // vsync clear has priority over a coincident end-of-line edge
      if (!vsync_in)
        row_cnt <= '0;
      else if (de_in_d && !de_in && (row_cnt != CNT_MAX))
        row_cnt <= row_cnt + 1'b1;
    end
  end

  assign mask = de_in & ((col_cnt < CNT_W'(BORDER)) | (row_cnt < CNT_W'(BORDER)));

endmodule

// File: rtl/sobel_window_filter.sv
// Three-stage Sobel gradient magnitude on a 3x3 window, producing a binary
// edge map or saturated magnitude with de/hsync/vsync realigned to the output.
`timescale 1ns/1ps
module sobel_window_filter
  import sobel_pkg::*;
#(
  parameter logic [MAG_W-1:0] THRESH = 11'd100,
  parameter bit               BINARY = 1'b1
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] win11,
  input  logic [PIX_W-1:0] win12,
  input  logic [PIX_W-1:0] win13,
  input  logic [PIX_W-1:0] win21,
  input  logic [PIX_W-1:0] win22,
  input  logic [PIX_W-1:0] win23,
  input  logic [PIX_W-1:0] win31,
  input  logic [PIX_W-1:0] win32,
  input  logic [PIX_W-1:0] win33,
  input  logic             de_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [PIX_W-1:0] edge_data,
  output logic             de_out,
  output logic             hsync_out,
  output logic             vsync_out
);

  logic             mask;
  logic [SUM_W-1:0] s1_r, s1_l, s1_b, s1_t;
  logic [SUM_W-1:0] s2_ax, s2_ay;
  logic [1:0]       mask_pipe;
  logic [2:0]       de_pipe, hs_pipe, vs_pipe;
  logic [MAG_W-1:0] mag;
  logic [PIX_W-1:0] pix_next;

  sobel_border_ctrl u_border (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .de_in    (de_in),
    .vsync_in (vsync_in),
    .mask     (mask)
  );

  // win22 has a zero coefficient in both kernels.
  logic unused_centre;
  assign unused_centre = ^win22;

  // NOTE: every path through this block assigns both outputs first, so no
  // latch can be inferred when a branch is added later.
  always_comb begin
    mag      = MAG_W'(s2_ax) + MAG_W'(s2_ay);
    pix_next = '0;
    if (mask_pipe[1])
      pix_next = '0;
    else if (BINARY)
      pix_next = (mag >= THRESH) ? '1 : '0;
    else
      pix_next = (mag > MAG_W'(255)) ? '1 : mag[PIX_W-1:0];
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      s1_r      <= '0;
      s1_l      <= '0;
      s1_b      <= '0;
      s1_t      <= '0;
      s2_ax     <= '0;
      s2_ay     <= '0;
      mask_pipe <= '0;
      de_pipe   <= '0;
      hs_pipe   <= '0;
      vs_pipe   <= '0;
      edge_data <= '0;
    end else begin
      // Column 1 is the newest pixel, so R/L are the right/left kernel columns.
      s1_r <= tap_sum(win11, win21, win31);
      s1_l <= tap_sum(win13, win23, win33);
      s1_b <= tap_sum(win31, win32, win33);
      s1_t <= tap_sum(win11, win12, win13);

      s2_ax <= abs_diff(s1_r, s1_l);
      s2_ay <= abs_diff(s1_b, s1_t);

      edge_data <= pix_next;

      mask_pipe <= {mask_pipe[0], mask};
      de_pipe   <= {de_pipe[1:0], de_in};
      hs_pipe   <= {hs_pipe[1:0], hsync_in};
      vs_pipe   <= {vs_pipe[1:0], vsync_in};
    end
  end

  assign de_out    = de_pipe[2];
  assign hsync_out = hs_pipe[2];
  assign vsync_out = vs_pipe[2];

endmodule

// File: doc/sobel_window_filter.md
# sobel_window_filter

- Consumes the 3×3 grey-scale window and delayed syncs produced by the line-buffer stage.
- Computes a Sobel gradient magnitude per pixel in a 3-stage pipeline.
- Emits a binary edge map, or a saturated magnitude, with de/hsync/vsync realigned to the output.
- Sits between the line buffer and the VGA output/colour-expansion stage.

## Interface

Parameters:
- THRESH, 100: magnitude threshold, 11-bit unsigned.
- BINARY, 1: 1 = output 255/0 against THRESH; 0 = output min(magnitude, 255).

Ports:
- pclk  in  1  pixel clock.
- rst_n  in  1  reset, synchronous, active-low.
- win11..win33  in  8 each  window pixels.
  - Row 1 is the top line (two lines old); row 3 is the current line.
  - Column 1 is the newest, rightmost pixel; column 3 is the oldest, leftmost pixel.
- de_in  in  1  data enable, aligned with the window.
- hsync_in  in  1  aligned with the window.
- vsync_in  in  1  aligned with the window; active level is low.
- edge_data  out  8  filtered pixel.
- de_out  out  1  de_in delayed by 3 cycles.
- hsync_out  out  1  hsync_in delayed by 3 cycles.
- vsync_out  out  1  vsync_in delayed by 3 cycles.

## Operation

- **Stage 1** (registered):
  - R = w11 + 2·w21 + w31
  - L = w13 + 2·w23 + w33
  - B = w31 + 2·w32 + w33
  - T = w11 + 2·w12 + w13
  - Each sum is 10-bit unsigned, max 1020.
- **Stage 2** (registered):
  - ax = |R − L|, ay = |B − T|.
  - Differences are computed at 11-bit signed width; absolute values are 10-bit.
- **Stage 3** (registered):
  - mag = ax + ay, 11-bit, max 2040, no overflow.
  - BINARY=1: edge_data = 255 if mag ≥ THRESH, else 0.
  - BINARY=0: edge_data = 255 if mag > 255, else mag[7:0].
  - If the stage-3 mask bit is set, edge_data = 0 regardless of mode.
- **Column counter** (10-bit):
  - Increments on each cycle with de_in=1.
  - Clears on each cycle with de_in=0.
  - Saturates at 1023.
- **Row counter** (10-bit):
  - Increments on each falling edge of de_in, i.e. de_in_d=1 and de_in=0.
  - Clears while vsync_in=0.
  - Saturates at 1023.
  - If vsync_in=0 and a de falling edge occur in the same cycle, clear wins.
- **Mask:**
  - mask = de_in & (col_cnt < 2 | row_cnt < 2), evaluated in the same cycle as the window input.
  - The mask travels with the data through all three stages.
  - It forces black on the first two columns and first two lines, where the window straddles stale or previous-line data.
- Outside active video (de_out=0), edge_data carries whatever the pipeline computed. Downstream qualifies on de_out.

## Timing

- Latency is exactly 3 cycles for data, de, hsync and vsync alike: input at cycle N → output at cycle N+3.
- Throughput is one pixel per clock. There is no back-pressure and no stall.
- Reset:
  - All pipeline registers, counters, the de_in_d edge register and the mask pipe clear to 0.
  - edge_data=0, de_out=0, hsync_out=0, vsync_out=0 from the first clock edge with rst_n=0.
- Reset released mid-frame:
  - Row counter starts at 0, so the first two lines completed after release are fully masked.
  - Normal output resumes without waiting for vsync.
- The first valid outputs after reset appear 3 cycles after the first accepted input.

## Structure

- Shared package `sobel_pkg` holds:
  - PIX_W=8, SUM_W=10, DIFF_W=11, MAG_W=11, CNT_W=10.
  - Border width constant BORDER=2.
- Sub-module `sobel_border_ctrl` holds:
  - column counter, row counter, de edge detect, mask generation.
  - output: mask bit, 1 bit, combinational from counters and de_in.
- Arithmetic pipeline and sync delay chains live in the top module.

## Test plan

- **Flat image** (all pixels 128), BINARY=1, 640×480 frame → edge_data=0 on every de_out cycle.
- **Vertical step edge**: columns <320 = 0, ≥320 = 255, from line 2 onward → edge_data=255 on exactly two output columns per line; mag=1020.
  - BINARY=0 gives 255 (saturated) on those two columns and 0 elsewhere.
- **Threshold boundary**, THRESH=50, after two lines and two columns have passed:
  - Drive w11=25, others 0 → mag=50 → 255.
  - Drive w11=24 → mag=48 → 0.
- **Latency/alignment**:
  - de_in rises at cycle 100 → de_out rises at cycle 103.
  - hsync/vsync pulses reappear 3 cycles later with identical width.
- **Border mask**: random window data → edge_data=0 for every pixel in rows 0–1 and columns 0–1 of each frame; nonzero output is allowed elsewhere.
- **Reset mid-frame**:
  - Assert rst_n=0 for 2 cycles at line 200 → all outputs 0 on the following edge.
  - The next two completed lines output 0.
  - The third line resumes normal filtering.
